manch_tx_ctrl: RTL and testbench

MANCH_TX_CTRL -- requirements
Module: manch_tx_ctrl

---
 rtl/manch_pkg.sv | 30 +++
 rtl/manch_bit_timer.sv | 47 ++++
 rtl/manch_tx_ctrl.sv | 153 +++++++++++++++
 tb/tb_manch_tx_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/manch_pkg.sv
// Shared types and constants for the Manchester frame transmitter controller.
package manch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HEADER  = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_PARITY  = 3'd3,
    ST_STOP    = 3'd4,
    ST_GAP     = 3'd5
  } state_e;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_HDR_LEN  = 9;
  localparam int DEF_BIT_DIV  = 8;
  localparam int DEF_GAP_BITS = 4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Cycles from an accepted request until tx_ready is high again.
  function automatic int frame_cycles(input int hdr_len, input int data_w,
                                      input int gap_bits, input int bit_div);
    return (hdr_len + data_w + 2 + gap_bits) * bit_div + 1;
  endfunction

endpackage

// File: rtl/manch_bit_timer.sv
// Bit-cell timer: counts 0..BIT_DIV-1 and flags the last and second-to-last cycles of a cell.
module manch_bit_timer
  import manch_pkg::*;
#(
  parameter int BIT_DIV = DEF_BIT_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic bit_end_o,
  output logic pre_end_o
);

  localparam logic [7:0] LAST_C = 8'(BIT_DIV - 1);
  localparam logic [7:0] PRE_C  = 8'(BIT_DIV - 2);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = 8'd0;
    end else if (enable_i) begin
      if (cnt_q == LAST_C) begin
        cnt_d = 8'd0;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end_o = enable_i && !clear_i && (cnt_q == LAST_C);
  assign pre_end_o = enable_i && !clear_i && (cnt_q == PRE_C);

endmodule

// File: rtl/manch_tx_ctrl.sv
// Frame sequencer feeding a Manchester modulator: header ones, payload MSB first,
// even parity, stop zero, then an idle gap before the next request is taken.
module manch_tx_ctrl
  import manch_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int HDR_LEN  = DEF_HDR_LEN,
  parameter int BIT_DIV  = DEF_BIT_DIV,
  parameter int GAP_BITS = DEF_GAP_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  input  logic              abort,
  output logic              mod_enable,
  output logic              mod_data,
  output logic              busy,
  output logic              tx_done
);

  localparam int BCNT_W = $clog2(max3(HDR_LEN, DATA_W, GAP_BITS) + 1);
  localparam logic [BCNT_W-1:0] HDR_LAST  = BCNT_W'(HDR_LEN - 1);
  localparam logic [BCNT_W-1:0] DATA_LAST = BCNT_W'(DATA_W - 1);
  localparam logic [BCNT_W-1:0] GAP_LAST  = BCNT_W'(GAP_BITS - 1);

  state_e              state_q;
  logic [BCNT_W-1:0]   bit_q;
  logic [DATA_W-1:0]   shift_q;
  logic [DATA_W-1:0]   shift_d;
  logic                parity_q;
  logic                mod_enable_q;
  logic                mod_data_q;
  logic                tx_done_q;

  logic                active;
  logic                abort_hit;
  logic                transfer;
  logic                bit_end;
  logic                pre_end;

  assign active    = (state_q != ST_IDLE);
  assign abort_hit = active && abort;
  assign transfer  = !active && tx_valid && !abort;
  assign shift_d   = {shift_q[DATA_W-2:0], 1'b0};

  manch_bit_timer #(
    .BIT_DIV(BIT_DIV)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (transfer || abort_hit),
    .enable_i (active),
    .bit_end_o(bit_end),
    .pre_end_o(pre_end)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      bit_q        <= '0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      mod_enable_q <= 1'b0;
      mod_data_q   <= 1'b0;
      tx_done_q    <= 1'b0;
    end else if (abort_hit) begin
      state_q      <= ST_IDLE;
      bit_q        <= '0;
      mod_enable_q <= 1'b0;
      mod_data_q   <= 1'b0;
      tx_done_q    <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (transfer) begin
            state_q      <= ST_HEADER;
            bit_q        <= '0;
            shift_q      <= tx_data;
            parity_q     <= ^tx_data;
            mod_enable_q <= 1'b1;
            mod_data_q   <= 1'b1;
          end
        end
        ST_HEADER: begin
          if (bit_end) begin
            if (bit_q == HDR_LAST) begin
              state_q    <= ST_PAYLOAD;
              bit_q      <= '0;
              mod_data_q <= shift_q[DATA_W-1];
            end else begin
              bit_q <= bit_q + BCNT_W'(1);
            end
          end
        end
        ST_PAYLOAD: begin
          if (bit_end) begin
            shift_q <= shift_d;
            if (bit_q == DATA_LAST) begin
              state_q    <= ST_PARITY;
              bit_q      <= '0;
              mod_data_q <= parity_q;
            end else begin
              bit_q      <= bit_q + BCNT_W'(1);
              mod_data_q <= shift_d[DATA_W-1];
            end
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            state_q    <= ST_STOP;
            mod_data_q <= 1'b0;
          end
        end
        ST_STOP: begin
          // Registered pulse lands on the final cycle of the stop bit.
          tx_done_q <= pre_end;
          if (bit_end) begin
            state_q      <= ST_GAP;
            bit_q        <= '0;
            mod_enable_q <= 1'b0;
            mod_data_q   <= 1'b0;
          end
        end
        ST_GAP: begin
          if (bit_end) begin
            if (bit_q == GAP_LAST) begin
              state_q <= ST_IDLE;
              bit_q   <= '0;
            end else begin
              bit_q <= bit_q + BCNT_W'(1);
            end
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          bit_q        <= '0;
          mod_enable_q <= 1'b0;
          mod_data_q   <= 1'b0;
        end
      endcase
    end
  end

  assign tx_ready   = !active;
  assign busy       = active;
  assign mod_enable = mod_enable_q;
  assign mod_data   = mod_data_q;
  assign tx_done    = tx_done_q;

endmodule

// File: tb/tb_manch_tx_ctrl.sv
// Directed bench for manch_tx_ctrl: default-parameter frames plus a small configuration.
module tb_manch_tx_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        tx_valid, abort, tx_ready, mod_enable, mod_data, busy, tx_done;
  logic [15:0] tx_data;
  logic        s_valid, s_abort, s_ready, s_en, s_mdata, s_busy, s_done;
  logic [3:0]  s_data;

  int tests_run    = 0;
  int tests_failed = 0;

  manch_tx_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .abort     (abort),
    .mod_enable(mod_enable),
    .mod_data  (mod_data),
    .busy      (busy),
    .tx_done   (tx_done)
  );

  manch_tx_ctrl #(
    .DATA_W(4), .HDR_LEN(1), .BIT_DIV(2), .GAP_BITS(1)
  ) dut_small (
    .clk       (clk),
    .rst       (rst),
    .tx_valid  (s_valid),
    .tx_data   (s_data),
    .tx_ready  (s_ready),
    .abort     (s_abort),
    .mod_enable(s_en),
    .mod_data  (s_mdata),
    .busy      (s_busy),
    .tx_done   (s_done)
  );

  // Output tuple order everywhere: {mod_enable, mod_data, tx_done, tx_ready, busy}.
  task automatic run_frame(input logic [15:0] data, input logic par, input logic hold,
                           input string name);
    logic [26:0] fb;
    logic [4:0]  exp_v;
    logic [4:0]  got_v;
    fb       = {9'h1FF, data, par, 1'b0};
    tx_valid = 1'b1;
    tx_data  = data;
    for (int c = 1; c <= 249; c++) begin
      @(negedge clk);
      if (c <= 216)      exp_v = {1'b1, fb[26 - (c - 1) / 8], (c == 216), 1'b0, 1'b1};
      else if (c <= 248) exp_v = 5'b00001;
      else               exp_v = 5'b00010;
      got_v = {mod_enable, mod_data, tx_done, tx_ready, busy};
      tests_run++;
      if (got_v !== exp_v) begin
        tests_failed++;
        $display("FAIL %s cycle %0d: got %b expected %b", name, c, got_v, exp_v);
      end
      if (c < 249) begin
        if (!hold) tx_valid = 1'b0;
        tx_data = 16'($urandom);
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests_run++;
    if ({mod_enable, mod_data, tx_done, tx_ready, busy} !== 5'b00010) begin
      tests_failed++;
      $display("FAIL reset_held: got %b expected 00010",
               {mod_enable, mod_data, tx_done, tx_ready, busy});
    end
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({mod_enable, mod_data, tx_done, tx_ready, busy, s_en, s_ready} !== 7'b0001001) begin
      tests_failed++;
      $display("FAIL reset_released: got %b expected 0001001",
               {mod_enable, mod_data, tx_done, tx_ready, busy, s_en, s_ready});
    end
  endtask

  task automatic test_basic();
    run_frame(16'hA5C3, 1'b0, 1'b0, "frame_a5c3");
  endtask

  task automatic test_parity();
    run_frame(16'h0001, 1'b1, 1'b0, "parity_0001");
    run_frame(16'h0000, 1'b0, 1'b0, "parity_0000");
  endtask

  task automatic test_abort();
    tx_valid = 1'b1;
    tx_data  = 16'hA5C3;
    for (int c = 1; c <= 115; c++) begin
      @(negedge clk);
      tx_valid = 1'b0;
    end
    // Cycle 115 sits inside payload bit 5, which is '1' for A5C3.
    tests_run++;
    if ({mod_enable, mod_data, tx_done, busy} !== 4'b1101) begin
      tests_failed++;
      $display("FAIL abort_pre_bit5: got %b expected 1101", {mod_enable, mod_data, tx_done, busy});
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    tests_run++;
    if ({mod_enable, mod_data, tx_done, tx_ready, busy} !== 5'b00010) begin
      tests_failed++;
      $display("FAIL abort_idle_next: got %b expected 00010",
               {mod_enable, mod_data, tx_done, tx_ready, busy});
    end
    run_frame(16'h1234, 1'b1, 1'b0, "post_abort_1234");
  endtask

  task automatic test_abort_idle();
    abort    = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 16'hFFFF;
    @(negedge clk);
    tests_run++;
    if ({mod_enable, mod_data, tx_done, tx_ready, busy} !== 5'b00010) begin
      tests_failed++;
      $display("FAIL abort_wins_idle: got %b expected 00010",
               {mod_enable, mod_data, tx_done, tx_ready, busy});
    end
    abort    = 1'b0;
    tx_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({mod_enable, busy} !== 2'b00) begin
      tests_failed++;
      $display("FAIL abort_no_queue: got %b expected 00", {mod_enable, busy});
    end
  endtask

  task automatic test_async_reset();
    tx_valid = 1'b1;
    tx_data  = 16'hFFFF;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      tx_valid = 1'b0;
    end
    tests_run++;
    if ({mod_enable, mod_data, busy} !== 3'b111) begin
      tests_failed++;
      $display("FAIL async_pre_header: got %b expected 111", {mod_enable, mod_data, busy});
    end
    #1 rst = 1'b1;
    #1;
    tests_run++;
    if ({mod_enable, mod_data, tx_done, tx_ready, busy} !== 5'b00010) begin
      tests_failed++;
      $display("FAIL async_reset_now: got %b expected 00010",
               {mod_enable, mod_data, tx_done, tx_ready, busy});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({mod_enable, mod_data, tx_done, tx_ready, busy} !== 5'b00010) begin
      tests_failed++;
      $display("FAIL async_reset_after: got %b expected 00010",
               {mod_enable, mod_data, tx_done, tx_ready, busy});
    end
  endtask

  task automatic test_back_to_back();
    run_frame(16'h00FF, 1'b0, 1'b1, "b2b_first");
    run_frame(16'h3C5B, 1'b1, 1'b1, "b2b_second");
    tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({mod_enable, tx_ready, busy} !== 3'b010) begin
      tests_failed++;
      $display("FAIL b2b_final_idle: got %b expected 010", {mod_enable, tx_ready, busy});
    end
  endtask

  task automatic small_frame(input logic [3:0] data, input logic [6:0] fb, input string name);
    logic [4:0] exp_v;
    logic [4:0] got_v;
    s_valid = 1'b1;
    s_data  = data;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      if (c <= 14)      exp_v = {1'b1, fb[6 - (c - 1) / 2], (c == 14), 1'b0, 1'b1};
      else if (c <= 16) exp_v = 5'b00001;
      else              exp_v = 5'b00010;
      got_v = {s_en, s_mdata, s_done, s_ready, s_busy};
      tests_run++;
      if (got_v !== exp_v) begin
        tests_failed++;
        $display("FAIL %s cycle %0d: got %b expected %b", name, c, got_v, exp_v);
      end
      s_valid = 1'b0;
      s_data  = 4'($urandom);
    end
  endtask

  task automatic test_small_cfg();
    small_frame(4'b1011, 7'b1101110, "small_1011");
    small_frame(4'b0110, 7'b1011000, "small_0110");
  endtask

  initial begin
    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 16'h0000;
    abort    = 1'b0;
    s_valid  = 1'b0;
    s_data   = 4'h0;
    s_abort  = 1'b0;
    test_reset();
    test_basic();
    test_parity();
    test_abort();
    test_abort_idle();
    test_async_reset();
    test_back_to_back();
    test_small_cfg();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
